bist_march_ctrl: RTL and testbench



---
 rtl/bist_march_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- memory BIST sequencer for a single-port SRAM.
// It walks the six March C- elements over words 0..DEPTH-1 and checks each
// read one cycle after it is issued. It reports busy/done/fail and captures
// the first failing address and element.
//
// Build option: define BIST_DIAG_EN to keep running after a mismatch and
// count mismatches in err_cnt_o. The default build stops at the first fail.
//
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   start_i        request a test; sampled in IDLE or DONE only
//   busy_o/done_o  test in progress / finished (done held until next start)
//   fail_o         at least one mismatch seen
//   fail_addr_o    address of first mismatch
//   fail_elem_o    March element (0..5) of first mismatch
//   err_cnt_o      saturating mismatch count (BIST_DIAG_EN only, else 0)
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o   SRAM request
//   mem_rdata_i    SRAM read data, valid the cycle after a read strobe
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing one SRAM operation per cycle
// DRAIN | last read in flight, its compare is consumed here
// DONE  | finished, results held, start accepted
module bist_march_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [2:0]        fail_elem_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          elem_q, elem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                phase_q, phase_d;   // 0 = read half, 1 = write half

    logic                rd_vld_q;
    logic [DATA_W-1:0]   exp_q;
    logic [2:0]          rd_elem_q;
    logic [ADDR_W-1:0]   rd_addr_q;

    logic                fail_q;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic [2:0]          fail_elem_q;

    logic single_op, is_read, down, rd_ones, wr_ones;
    logic addr_end, last_op, start_ok, in_test, mismatch;

    // element decode: M0 w0 and M5 r0 are single-op, the rest are read+write
    assign single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
    assign is_read   = (elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q);
    assign down      = (elem_q >= 3'd3);
    assign rd_ones   = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign wr_ones   = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign addr_end  = down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign last_op   = (elem_q == 3'd5) && addr_end;
    assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign in_test   = (state_q == S_RUN) || (state_q == S_DRAIN);
    // a compare left over from an aborted run lands in DONE and is ignored
    assign mismatch  = rd_vld_q && in_test && (mem_rdata_i != exp_q);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN: begin
`ifdef BIST_DIAG_EN
                if (last_op) state_d = S_DRAIN;
`else
                if (mismatch)     state_d = S_DONE;
                else if (last_op) state_d = S_DRAIN;
`endif
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy_o      = in_test;
        done_o      = (state_q == S_DONE);
        mem_en_o    = (state_q == S_RUN);
        mem_we_o    = (state_q == S_RUN) && !is_read;
        mem_addr_o  = (state_q == S_RUN) ? addr_q : '0;
        mem_wdata_o = ((state_q == S_RUN) && !is_read && wr_ones) ? '1 : '0;
        fail_o      = fail_q;
        fail_addr_o = fail_addr_q;
        fail_elem_o = fail_elem_q;
    end

    // operation sequencer: phase within address, address within element
    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        if (start_ok) begin
            elem_d  = 3'd0;
            addr_d  = '0;
            phase_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (!single_op && !phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!addr_end) begin
                    addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                end else if (elem_q != 3'd5) begin
                    elem_d = elem_q + 3'd1;
                    // M0..M2 ascend, M3..M5 descend from the top word
                    addr_d = (elem_q >= 3'd2) ? LAST_ADDR : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q    <= '0;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            exp_q     <= '0;
            rd_elem_q <= '0;
            rd_addr_q <= '0;
        end else begin
            elem_q    <= elem_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            rd_vld_q  <= (state_q == S_RUN) && is_read;
            exp_q     <= rd_ones ? '1 : '0;
            rd_elem_q <= elem_q;
            rd_addr_q <= addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else if (start_ok) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else if (mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= rd_addr_q;
            fail_elem_q <= rd_elem_q;
        end
    end

`ifdef BIST_DIAG_EN
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt_q <= '0;
        else if (start_ok)                   err_cnt_q <= '0;
        else if (mismatch && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bist_march_ctrl.sv
module tb_bist_march_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // DEPTH=8 instance with optional stuck-at faults
    logic       start8, busy8, done8, fail8, en8, we8;
    logic [3:0] addr8, faddr8;
    logic [2:0] felem8;
    logic [7:0] err8, wd8, rd8;
    logic [7:0] mem8 [16];
    bit         faults = 1'b0;

    // DEPTH=6, ADDR_W=3 instance
    logic       start6, busy6, done6, fail6, en6, we6;
    logic [2:0] addr6, faddr6;
    logic [2:0] felem6;
    logic [7:0] err6, wd6, rd6;
    logic [7:0] mem6 [8];

    bist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(8), .ERR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8),
        .busy_o(busy8), .done_o(done8), .fail_o(fail8),
        .fail_addr_o(faddr8), .fail_elem_o(felem8), .err_cnt_o(err8),
        .mem_en_o(en8), .mem_we_o(we8), .mem_addr_o(addr8),
        .mem_wdata_o(wd8), .mem_rdata_i(rd8)
    );

    bist_march_ctrl #(.ADDR_W(3), .DATA_W(8), .DEPTH(6), .ERR_W(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start_i(start6),
        .busy_o(busy6), .done_o(done6), .fail_o(fail6),
        .fail_addr_o(faddr6), .fail_elem_o(felem6), .err_cnt_o(err6),
        .mem_en_o(en6), .mem_we_o(we6), .mem_addr_o(addr6),
        .mem_wdata_o(wd6), .mem_rdata_i(rd6)
    );

    // address 5 bit 3 stuck-at-1, address 2 bit 0 stuck-at-0
    function automatic logic [7:0] fault8(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (faults && a == 4'd5) r = r | 8'h08;
        if (faults && a == 4'd2) r = r & 8'hFE;
        return r;
    endfunction

    always @(posedge clk) begin
        if (en8) begin
            if (we8) mem8[addr8] <= wd8;
            else     rd8 <= fault8(addr8, mem8[addr8]);
        end
        if (en6) begin
            if (we6) mem6[addr6] <= wd6;
            else     rd6 <= mem6[addr6];
        end
    end

    bit         sel = 1'b0;   // 0 = DEPTH 8 instance, 1 = DEPTH 6 instance
    logic       o_en, o_we, o_done, o_busy;
    logic [3:0] o_addr;
    logic [7:0] o_wd;
    assign o_en   = sel ? en6   : en8;
    assign o_we   = sel ? we6   : we8;
    assign o_done = sel ? done6 : done8;
    assign o_busy = sel ? busy6 : busy8;
    assign o_addr = sel ? {1'b0, addr6} : addr8;
    assign o_wd   = sel ? wd6   : wd8;

    logic [12:0] op_log [100];   // {addr, we, wdata} per operation slot

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses (or holds) start, returns edges after acceptance until done.
    task automatic run(input bit hold, output int done_edge, output int en_cnt,
                       output int max_addr, output bit busy0, output bit en_at_done);
        if (sel) start6 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin start6 = 1'b0; start8 = 1'b0; end
        done_edge = -1; en_cnt = 0; max_addr = 0; busy0 = o_busy; en_at_done = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (o_done) begin
                done_edge  = n;
                en_at_done = o_en;
                break;
            end
            if (o_en) en_cnt++;
            if (n < 100) op_log[n] = {o_addr, o_we, o_wd};
            if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
            @(posedge clk); #1;
        end
        start6 = 1'b0; start8 = 1'b0;
    endtask

    int de, ec, ma;
    bit b0, ead;

    initial begin
        start8 = 1'b0;
        start6 = 1'b0;
        #1;
        check("rst_outs8", {busy8, done8, fail8, en8, we8, addr8, wd8, faddr8, felem8, err8}, 0);
        check("rst_outs6", {busy6, done6, fail6, en6, we6, addr6, wd6}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy8, 0);

        // fault-free DEPTH=8 run
        sel = 1'b0;
        run(1'b0, de, ec, ma, b0, ead);
        check("s1_done_edge", de, 81);
        check("s1_en_cnt", ec, 80);
        check("s1_busy_e", b0, 1);
        check("s1_fail", fail8, 0);
        check("s1_busy_done", busy8, 0);
        check("s1_op0",  op_log[0],  {4'd0, 1'b1, 8'h00});
        check("s1_op7",  op_log[7],  {4'd7, 1'b1, 8'h00});
        check("s1_op8",  op_log[8],  {4'd0, 1'b0, 8'h00});
        check("s1_op9",  op_log[9],  {4'd0, 1'b1, 8'hFF});
        check("s1_op25", op_log[25], {4'd0, 1'b1, 8'h00});
        check("s1_op40", op_log[40], {4'd7, 1'b0, 8'h00});
        check("s1_op41", op_log[41], {4'd7, 1'b1, 8'hFF});
        check("s1_op72", op_log[72], {4'd7, 1'b0, 8'h00});
        check("s1_op79", op_log[79], {4'd0, 1'b0, 8'h00});
        repeat (3) @(posedge clk); #1;
        check("s1_done_held", done8, 1);

        // DEPTH=6, ADDR_W=3
        sel = 1'b1;
        run(1'b0, de, ec, ma, b0, ead);
        check("s3_done_edge", de, 61);
        check("s3_en_cnt", ec, 60);
        check("s3_max_addr", ma, 5);
        check("s3_m2_last", op_log[29], {4'd5, 1'b1, 8'h00});
        check("s3_m3_first", op_log[30], {4'd5, 1'b0, 8'h00});
        check("s3_m5_last", op_log[59], {4'd0, 1'b0, 8'h00});
        check("s3_fail", fail6, 0);

        // start held through the whole run
        sel = 1'b0;
        run(1'b1, de, ec, ma, b0, ead);
        check("s4_done_edge", de, 81);
        repeat (5) @(posedge clk); #1;
        check("s4_no_restart", {done8, busy8}, 2'b10);
        run(1'b0, de, ec, ma, b0, ead);
        check("s4_rerun_edge", de, 81);
        check("s4_rerun_busy", b0, 1);

        // stuck-at faults
        faults = 1'b1;
        run(1'b0, de, ec, ma, b0, ead);
`ifdef BIST_DIAG_EN
        check("s6_done_edge", de, 81);
        check("s6_en_cnt", ec, 80);
        check("s6_err_cnt", err8, 5);
`else
        check("s2_done_edge", de, 20);
        check("s2_en_cnt", ec, 20);
        check("s2_err_cnt", err8, 0);
`endif
        check("sf_en_at_done", ead, 0);
        check("sf_fail", fail8, 1);
        check("sf_fail_addr", faddr8, 5);
        check("sf_fail_elem", felem8, 1);
        repeat (3) @(posedge clk); #1;
        check("sf_hold", {en8, busy8, done8, faddr8, felem8}, {1'b0, 1'b0, 1'b1, 4'd5, 3'd1});

        // reset mid-run
        faults = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("s5_cleared", {fail8, done8, busy8}, 3'b001);
        repeat (30) @(posedge clk);
        #1;
        check("s5_running", en8, 1);
        rst_n = 1'b0;
        #1;
        check("s5_async_rst", {busy8, done8, fail8, en8, we8, addr8, wd8, faddr8, felem8, err8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s5_idle", {busy8, done8}, 0);
        run(1'b0, de, ec, ma, b0, ead);
        check("s5_done_edge", de, 81);
        check("s5_fail", {fail8, faddr8, felem8}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
